// File: rtl/lzrw1_pkg.sv
// Shared types and helpers for the LZRW1 stream decompressor.
//   state_t      : control FSM states
//   token_fields : decoded copy item (offset, expanded length)
//   decode_token : splits a copy item into offset and length
package lzrw1_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        ERROR = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] offset;
        logic [31:0] length;
    } token_fields_t;

    // The token is passed zero-extended so the helper serves any field widths.
    function automatic token_fields_t decode_token(
        input logic [63:0] token,
        input int unsigned offset_bits,
        input int unsigned len_bits,
        input int unsigned min_match
    );
        token_fields_t f;
        logic [63:0]   off_mask;
        logic [63:0]   len_mask;
        off_mask = (64'd1 << offset_bits) - 64'd1;
        len_mask = (64'd1 << len_bits) - 64'd1;
        f.offset = 32'(token & off_mask);
        f.length = 32'((token >> offset_bits) & len_mask) + 32'(min_match);
        return f;
    endfunction

endpackage

// File: rtl/lzrw1_history_ram.sv
// Byte history buffer: one write port, one synchronous read port.
// A read of the address written in the same cycle returns the new byte.
//   clock            : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read request, data on rd_data one cycle later
//   rd_data          : held while rd_en is low
module lzrw1_history_ram
    import lzrw1_pkg::*;
#(
    parameter  int unsigned DEPTH = 4096,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Write-first bypass makes offset-1 copies replicate the byte just written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 item decompressor: literal or copy items in, one byte per cycle out,
// ready/valid on both sides.
//   clock, reset       : clock, async active-low reset
//   clear              : synchronous block restart (history, copy, error)
//   in_data/in_is_copy/in_last/in_valid/in_ready : item stream
//   out_byte/out_valid/out_ready/out_last        : byte stream
//   busy               : copy in progress or output held by sink
//   err_offset         : sticky invalid-offset flag
module lzrw1_stream_decompressor
    import lzrw1_pkg::*;
#(
    parameter  int unsigned OFFSET_BITS   = 12,
    parameter  int unsigned LEN_BITS      = 4,
    parameter  int unsigned MIN_MATCH     = 3,
    parameter  int unsigned HISTORY_DEPTH = 4096,
    localparam int unsigned TOKEN_W       = OFFSET_BITS + LEN_BITS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [TOKEN_W-1:0] in_data,
    input  logic               in_is_copy,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BYTE_W-1:0]  out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               err_offset
);

    localparam int unsigned AW      = $clog2(HISTORY_DEPTH);
    localparam int unsigned FW      = AW + 1;
    localparam int unsigned CW      = $clog2((2 ** LEN_BITS) + MIN_MATCH);
    localparam int unsigned MAX_OFF = HISTORY_DEPTH - 1;

    state_t            state;
    state_t            state_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     src;
    logic [FW-1:0]     fill;
    logic [CW-1:0]     rd_left;
    logic              q_valid;
    logic              last_item;
    logic [BYTE_W-1:0] ram_q;
    logic [BYTE_W-1:0] ram_wdata;
    logic              ram_we;
    logic              out_free;
    logic              lit_accept;
    logic              copy_accept;
    logic              consume;
    logic              issue;
    logic              copy_done;
    logic              offset_ok;
    token_fields_t     tok;
    int unsigned       off_limit;

    // Copy item decode and offset validation against bytes actually held.
    always_comb begin
        tok       = decode_token(64'(in_data), OFFSET_BITS, LEN_BITS, MIN_MATCH);
        off_limit = (32'(fill) < MAX_OFF) ? 32'(fill) : MAX_OFF;
        offset_ok = (tok.offset != 32'd0) && (tok.offset <= off_limit);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (copy_accept) state_d = offset_ok ? COPY : ERROR;
                COPY:    if (copy_done) state_d = IDLE;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control strobes and handshake outputs.
    // A read is only issued when the previous read's byte leaves ram_q in the
    // same cycle, so the bypass always covers the byte being written.
    always_comb begin
        in_ready = 1'b0;
        consume  = 1'b0;
        issue    = 1'b0;
        out_free = !out_valid || out_ready;
        case (state)
            IDLE: in_ready = out_free;
            COPY: begin
                consume = q_valid && out_free && !clear;
                issue   = (rd_left != '0) && (!q_valid || consume) && !clear;
            end
            default: ;
        endcase
        lit_accept  = in_valid && in_ready && !in_is_copy && !clear;
        copy_accept = in_valid && in_ready && in_is_copy && !clear;
        copy_done   = (rd_left == '0) && !q_valid && out_free;
        ram_we      = lit_accept || consume;
        ram_wdata   = consume ? ram_q : in_data[BYTE_W-1:0];
        busy        = (state != IDLE) || (out_valid && !out_ready);
    end

    // Output register, history pointers and copy sequencing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_byte   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            err_offset <= 1'b0;
            wr_ptr     <= '0;
            fill       <= '0;
            src        <= '0;
            rd_left    <= '0;
            q_valid    <= 1'b0;
            last_item  <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            err_offset <= 1'b0;
            wr_ptr     <= '0;
            fill       <= '0;
            rd_left    <= '0;
            q_valid    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (lit_accept) begin
                out_byte  <= in_data[BYTE_W-1:0];
                out_valid <= 1'b1;
                out_last  <= in_last;
            end
            if (consume) begin
                out_byte  <= ram_q;
                out_valid <= 1'b1;
                out_last  <= last_item && (rd_left == '0);
            end
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FW'(HISTORY_DEPTH)) begin
                    fill <= fill + FW'(1);
                end
            end
            if (copy_accept) begin
                if (offset_ok) begin
                    src       <= wr_ptr - AW'(tok.offset);
                    rd_left   <= CW'(tok.length);
                    last_item <= in_last;
                end else begin
                    err_offset <= 1'b1;
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                end
            end
            if (issue) begin
                src     <= src + AW'(1);
                rd_left <= rd_left - CW'(1);
                q_valid <= 1'b1;
            end else if (consume) begin
                q_valid <= 1'b0;
            end
        end
    end

    lzrw1_history_ram #(
        .DEPTH (HISTORY_DEPTH)
    ) u_history (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (ram_wdata),
        .rd_en   (issue),
        .rd_addr (src),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_lzrw1_stream_decompressor.sv
// Self-checking bench: directed scenarios plus randomized item streams,
// compared against a byte-level model of the decompressed stream.
module tb_lzrw1_stream_decompressor;

    localparam int unsigned OB = 5;
    localparam int unsigned LB = 4;
    localparam int unsigned MM = 3;
    localparam int unsigned HD = 16;
    localparam int unsigned TW = OB + LB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [TW-1:0] in_data = '0;
    logic          in_is_copy = 1'b0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          err_offset;

    lzrw1_stream_decompressor #(
        .OFFSET_BITS   (OB),
        .LEN_BITS      (LB),
        .MIN_MATCH     (MM),
        .HISTORY_DEPTH (HD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_is_copy (in_is_copy),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .err_offset (err_offset)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int pidx     = 0;
    logic [5:0] pat = 6'b101001;

    logic [7:0] produced [$];
    logic [8:0] exp_q [$];
    logic       model_err = 1'b0;
    logic [7:0] seen [$];
    logic       seen_last [$];
    int         seen_t [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    logic       prev_last = 1'b0;
    logic [8:0] e;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: the decompressed stream as a plain byte list.
    function automatic void model_accept();
        int off;
        int len;
        int lim;
        int n;
        logic [7:0] b;
        if (!in_is_copy) begin
            b = in_data[7:0];
            produced.push_back(b);
            exp_q.push_back({in_last, b});
        end else begin
            off = int'(in_data[OB-1:0]);
            len = int'(in_data[TW-1:OB]) + int'(MM);
            lim = (produced.size() < int'(HD) - 1) ? produced.size() : int'(HD) - 1;
            if (off < 1 || off > lim) begin
                model_err = 1'b1;
            end else begin
                for (int k = 0; k < len; k++) begin
                    n = produced.size();
                    b = produced[n - off];
                    produced.push_back(b);
                    exp_q.push_back({in_last && (k == len - 1), b});
                end
            end
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Sink readiness.
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 6;
            end
            default: out_ready = ($urandom_range(0, 9) < 6);
        endcase
    end

    // Compare process: sample half a cycle away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            produced.delete();
            model_err  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("err_offset", err_offset == model_err, 32'(err_offset), 32'(model_err));
            if (model_err)
                check("error_quiet", !out_valid && !in_ready && busy,
                      32'({out_valid, in_ready, busy}), 32'(3'b001));
            if (prev_stall)
                check("stall_hold", out_valid && out_byte == prev_byte && out_last == prev_last,
                      32'({out_valid, out_last, out_byte}), 32'({1'b1, prev_last, prev_byte}));
            if (out_valid && out_ready) begin
                seen.push_back(out_byte);
                seen_last.push_back(out_last);
                seen_t.push_back(cyc);
                check("unexpected_byte", exp_q.size() != 0, 32'({out_last, out_byte}), 32'(0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_last_byte", {out_last, out_byte} == e, 32'({out_last, out_byte}), 32'(e));
                end
            end
            if (clear) begin
                exp_q.delete();
                produced.delete();
                model_err = 1'b0;
            end else if (in_valid && in_ready) begin
                model_accept();
            end
            prev_stall = out_valid && !out_ready && !clear;
            prev_byte  = out_byte;
            prev_last  = out_last;
        end
    end

    task automatic send(input logic cp, input logic [TW-1:0] d, input logic lst);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid   = 1'b1;
        in_is_copy = cp;
        in_data    = d;
        in_last    = lst;
        while (!ok && n < 300) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            n++;
        end
        if (!ok) check("send_timeout", ok, 32'(n), 32'(0));
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        in_is_copy = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic send_lit(input logic [7:0] b, input logic lst);
        send(1'b0, TW'(b), lst);
    endtask

    task automatic send_copy(input int off, input int code, input logic lst);
        send(1'b1, {LB'(code), OB'(off)}, lst);
    endtask

    task automatic pulse_clear();
        @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && n < 500) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        check("drain", exp_q.size() == 0 && !busy, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_seen(input string name, input string s);
        bit ok;
        ok = (seen.size() == s.len());
        for (int i = 0; i < s.len() && ok; i++)
            if (seen[i] != s[i]) ok = 1'b0;
        check(name, ok, 32'(seen.size()), 32'(s.len()));
    endtask

    task automatic clear_log();
        seen.delete();
        seen_last.delete();
        seen_t.delete();
    endtask

    initial begin
        int lim;
        int off;
        bit ok;

        // Reset state.
        #12;
        check("reset_outs", {out_valid, out_last, busy, err_offset, out_byte} == '0,
              32'({out_valid, out_last, busy, err_offset, out_byte}), 32'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        check("reset_in_ready", in_ready == 1'b1, 32'(in_ready), 32'(1));

        // 1: literals at full rate.
        clear_log();
        send_lit(8'h61, 1'b0);
        check("lit_latency", out_valid && out_byte == 8'h61, 32'({out_valid, out_byte}), 32'({1'b1, 8'h61}));
        send_lit(8'h62, 1'b0);
        send_lit(8'h63, 1'b0);

        // 2: copy offset 3, length 3.
        send_copy(3, 0, 1'b0);
        check("copy_lat0", !out_valid, 32'(out_valid), 32'(0));
        @(posedge clock); #1;
        check("copy_lat1", !out_valid, 32'(out_valid), 32'(0));
        @(posedge clock); #1;
        check("copy_first", out_valid && out_byte == 8'h61, 32'({out_valid, out_byte}), 32'({1'b1, 8'h61}));
        check("copy_ready0", !in_ready, 32'(in_ready), 32'(0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("copy_ready2", !in_ready, 32'(in_ready), 32'(0));
        @(posedge clock); #1;
        check("copy_ready_back", in_ready, 32'(in_ready), 32'(1));
        drain();
        check_seen("seq_abcabc", "abcabc");
        check("lit_rate", seen_t.size() >= 3 && seen_t[1] == seen_t[0] + 1 && seen_t[2] == seen_t[1] + 1,
              32'(seen_t.size()), 32'(3));

        // 3: overlapping copy with last marking.
        clear_log();
        send_lit(8'h78, 1'b0);
        send_copy(1, 2, 1'b1);
        drain();
        check_seen("seq_xxxxxx", "xxxxxx");
        ok = (seen_last.size() == 6);
        for (int i = 0; i < seen_last.size() && ok; i++)
            if (seen_last[i] != (i == 5)) ok = 1'b0;
        check("last_only_6th", ok, 32'(seen_last.size()), 32'(6));

        // 4: same as 2 under a stalling sink.
        pulse_clear();
        clear_log();
        rdy_mode = 1;
        send_lit(8'h61, 1'b0);
        send_lit(8'h62, 1'b0);
        send_lit(8'h63, 1'b0);
        send_copy(3, 0, 1'b0);
        drain();
        rdy_mode = 0;
        check_seen("seq_stalled", "abcabc");

        // 5: invalid offsets.
        pulse_clear();
        clear_log();
        send_copy(0, 0, 1'b0);
        check("off0_err", err_offset && !in_ready && !out_valid,
              32'({err_offset, in_ready, out_valid}), 32'(3'b100));
        pulse_clear();
        check("clear_recover", !err_offset && in_ready, 32'({err_offset, in_ready}), 32'(2'b01));
        send_lit(8'h31, 1'b0);
        send_lit(8'h32, 1'b0);
        drain();
        send_copy(5, 0, 1'b0);
        check("off5_err", err_offset && !in_ready && !out_valid,
              32'({err_offset, in_ready, out_valid}), 32'(3'b100));
        repeat (3) @(posedge clock);
        #1;
        check("err_sticky", err_offset && seen.size() == 2, 32'({err_offset, 8'(seen.size())}), 32'({1'b1, 8'd2}));
        pulse_clear();
        check("clear_recover2", !err_offset && in_ready, 32'({err_offset, in_ready}), 32'(2'b01));

        // 6: wrap-around, then reset mid-copy.
        clear_log();
        for (int i = 0; i < 20; i++) send_lit(8'(i), 1'b0);
        send_copy(15, 0, 1'b0);
        drain();
        check("wrap_copy", seen.size() == 23 && seen[20] == 8'h05 && seen[21] == 8'h06 && seen[22] == 8'h07,
              32'(seen.size() == 23 ? {seen[20], seen[21], seen[22]} : 24'hFFFFFF), 32'(24'h050607));
        send_copy(2, 15, 1'b1);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("reset_midcopy", {out_valid, out_last, busy, err_offset, out_byte} == '0,
              32'({out_valid, out_last, busy, err_offset, out_byte}), 32'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        drain();

        // Randomized streams with random sink readiness.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            lim = (produced.size() < int'(HD) - 1) ? produced.size() : int'(HD) - 1;
            if (lim == 0 || $urandom_range(0, 9) < 5) begin
                send_lit(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            end else if ($urandom_range(0, 24) == 0) begin
                off = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(lim + 1, 31));
                send_copy(off, int'($urandom_range(0, 15)), 1'b0);
                repeat (3) @(posedge clock);
                pulse_clear();
            end else begin
                off = int'($urandom_range(1, lim));
                send_copy(off, int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            end
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
